wb_protocol_monitor: RTL
========================

WB_PROTOCOL_MONITOR -- requirements
Module: wb_protocol_monitor

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 256, max cycles a strobe may wait for ack (>=2).
REQ-002 SHALL have parameter CNT_W, default 16, width of transfer counters and latency registers.
REQ-003 SHALL have port wb_clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port wb_rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wb_cyc_i  input  1  observed master cycle.
REQ-006 SHALL have port wb_stb_i  input  1  observed master strobe.
REQ-007 SHALL have port wb_we_i  input  1  observed write enable.
REQ-008 SHALL have port wb_sel_i  input  4  observed byte selects.
REQ-009 SHALL have port wb_addr_i  input  32  observed address.
REQ-010 SHALL have port wb_ack_o  input  1  observed slave ack (controller output, monitored here).
REQ-011 SHALL have port clr_i  input  1  clears error and statistics registers.
REQ-012 SHALL have port busy_o  output  1  a transfer is pending (state WAIT).
REQ-013 SHALL have port err_o  output  1  sticky: any error seen since reset/clear.
REQ-014 SHALL have port err_code_o  output  3  code of first error: 0 none, 1 ACK_NO_STB, 2 STB_NO_CYC, 3 TIMEOUT, 4 ATTR_CHG, 5 STB_DROP.
REQ-015 SHALL have port err_flags_o  output  5  sticky per-error flags, bit n-1 for code n.
REQ-016 SHALL have port rd_cnt_o  output  CNT_W  completed reads (ack with we=0).
REQ-017 SHALL have port wr_cnt_o  output  CNT_W  completed writes (ack with we=1).
REQ-018 SHALL have port max_lat_o  output  CNT_W  largest observed request-to-ack latency.

Function
REQ-019 SHALL implement FSM IDLE/WAIT; req = wb_cyc_i & wb_stb_i.
REQ-020 IDLE: req & !ack -> WAIT, capture addr/we/sel, lat_cnt=1; req & ack -> complete (latency 1), stay IDLE.
REQ-021 WAIT: ack & req -> complete, latency lat_cnt+1, -> IDLE; otherwise lat_cnt increments (saturating).
REQ-022 Completion SHALL increment rd_cnt_o or wr_cnt_o per wb_we_i of the ack cycle; both saturate at all-ones.
REQ-023 max_lat_o SHALL update to completion latency when strictly greater, one cycle after ack.
REQ-024 ACK_NO_STB: wb_ack_o high while req low, any state.
REQ-025 STB_NO_CYC: wb_stb_i high while wb_cyc_i low.
REQ-026 TIMEOUT: in WAIT, lat_cnt reaches TIMEOUT_CYC without ack; flag once, FSM -> IDLE, no count increment.
REQ-027 ATTR_CHG: in WAIT, req high and addr/we/sel differ from captured values; FSM stays WAIT.
REQ-028 STB_DROP: in WAIT, req falls without ack; FSM -> IDLE, no count increment.
REQ-029 Errors SHALL register one cycle after the offending cycle; err_o = |err_flags_o.
REQ-030 err_code_o SHALL latch only when currently 0; same-cycle multiple errors -> lowest code latched, all flags set.
REQ-031 clr_i SHALL zero flags, code, counters, max_lat next cycle; FSM and lat_cnt unaffected.
REQ-032 clr_i with simultaneous error or completion: clear applied first, new event recorded on top.
REQ-033 Monitor SHALL be passive: no outputs drive the bus; no combinational path inputs->outputs.

Reset
REQ-034 wb_rst_i high at a rising edge: FSM IDLE, lat_cnt 0, all outputs 0; dominates clr_i and all events.
REQ-035 Reset mid-transfer SHALL abandon it without error or count; bus activity during reset ignored.

Verification
REQ-036 Read: cyc=stb=1, we=0, ack on 3rd cycle -> rd_cnt_o=1, max_lat_o=3, err_o=0, busy_o high 2 cycles.
REQ-037 Zero-wait write: req and ack same cycle -> wr_cnt_o=1, max_lat_o=1, busy_o stays 0.
REQ-038 TIMEOUT_CYC=8, no ack -> err_code_o=3, err_flags_o=5'b00100, busy_o low, counts 0.
REQ-039 Ack with stb=0, cyc=1, then addr change in a later WAIT -> err_code_o=1, err_flags_o=5'b01001.
REQ-040 clr_i pulse after errors and 5 reads -> all outputs 0 next cycle; new read then rd_cnt_o=1.
REQ-041 wb_rst_i asserted in WAIT -> next cycle all outputs 0; later ack with stb=0 -> err_code_o=1.

Source files
------------

// File: rtl/wb_protocol_monitor.sv
// Passive Wishbone classic-cycle monitor: tracks one outstanding strobe,
// flags protocol violations and keeps read/write counts and worst-case latency.
module wb_protocol_monitor #(
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [3:0]       wb_sel_i,
  input  logic [31:0]      wb_addr_i,
  input  logic             wb_ack_o,
  input  logic             clr_i,
  output logic             busy_o,
  output logic             err_o,
  output logic [2:0]       err_code_o,
  output logic [4:0]       err_flags_o,
  output logic [CNT_W-1:0] rd_cnt_o,
  output logic [CNT_W-1:0] wr_cnt_o,
  output logic [CNT_W-1:0] max_lat_o
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_M1   = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] lat_cnt, lat_nxt, lat_inc;
  logic [31:0]      cap_addr;
  logic             cap_we;
  logic [3:0]       cap_sel;
  logic             capture;

  logic             req;
  logic             done;
  logic [CNT_W-1:0] done_lat;
  logic [4:0]       new_err;
  logic [2:0]       new_code;

  logic [4:0]       flags_base, flags_nxt;
  logic [2:0]       code_base, code_nxt;
  logic [CNT_W-1:0] rd_base, rd_nxt, wr_base, wr_nxt, max_base, max_nxt;

  // Transfer tracking; new_err bit n-1 corresponds to error code n.
  always_comb begin
    req       = wb_cyc_i & wb_stb_i;
    state_nxt = state;
    lat_nxt   = lat_cnt;
    lat_inc   = (lat_cnt == CNT_MAX) ? lat_cnt : lat_cnt + 1'b1;
    capture   = 1'b0;
    done      = 1'b0;
    done_lat  = '0;
    new_err   = '0;
    new_err[0] = wb_ack_o & ~req;
    new_err[1] = wb_stb_i & ~wb_cyc_i;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (wb_ack_o) begin
            done     = 1'b1;
            done_lat = CNT_W'(1);
          end else begin
            state_nxt = S_WAIT;
            lat_nxt   = CNT_W'(1);
            capture   = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (req) begin
          new_err[3] = (wb_addr_i != cap_addr) | (wb_we_i != cap_we) |
                       (wb_sel_i != cap_sel);
          if (wb_ack_o) begin
            done      = 1'b1;
            done_lat  = lat_inc;
            state_nxt = S_IDLE;
            lat_nxt   = '0;
          end else if (lat_cnt >= TO_M1) begin
            // This cycle is the TIMEOUT_CYC-th without ack: give up on it.
            new_err[2] = 1'b1;
            state_nxt  = S_IDLE;
            lat_nxt    = '0;
          end else begin
            lat_nxt = lat_inc;
          end
        end else begin
          new_err[4] = ~wb_ack_o;
          state_nxt  = S_IDLE;
          lat_nxt    = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Statistics: clear is applied first, then this cycle's events on top.
  always_comb begin
    if (new_err[0])      new_code = 3'd1;
    else if (new_err[1]) new_code = 3'd2;
    else if (new_err[2]) new_code = 3'd3;
    else if (new_err[3]) new_code = 3'd4;
    else if (new_err[4]) new_code = 3'd5;
    else                 new_code = 3'd0;

    flags_base = clr_i ? 5'd0 : err_flags_o;
    code_base  = clr_i ? 3'd0 : err_code_o;
    rd_base    = clr_i ? '0 : rd_cnt_o;
    wr_base    = clr_i ? '0 : wr_cnt_o;
    max_base   = clr_i ? '0 : max_lat_o;

    flags_nxt = flags_base | new_err;
    code_nxt  = (code_base == 3'd0) ? new_code : code_base;
    rd_nxt    = rd_base;
    wr_nxt    = wr_base;
    max_nxt   = max_base;
    if (done) begin
      if (wb_we_i) begin
        if (wr_base != CNT_MAX) wr_nxt = wr_base + 1'b1;
      end else begin
        if (rd_base != CNT_MAX) rd_nxt = rd_base + 1'b1;
      end
      if (done_lat > max_base) max_nxt = done_lat;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= S_IDLE;
      lat_cnt     <= '0;
      cap_addr    <= '0;
      cap_we      <= 1'b0;
      cap_sel     <= '0;
      err_flags_o <= '0;
      err_code_o  <= '0;
      rd_cnt_o    <= '0;
      wr_cnt_o    <= '0;
      max_lat_o   <= '0;
    end else begin
      state       <= state_nxt;
      lat_cnt     <= lat_nxt;
      if (capture) begin
        cap_addr <= wb_addr_i;
        cap_we   <= wb_we_i;
        cap_sel  <= wb_sel_i;
      end
      err_flags_o <= flags_nxt;
      err_code_o  <= code_nxt;
      rd_cnt_o    <= rd_nxt;
      wr_cnt_o    <= wr_nxt;
      max_lat_o   <= max_nxt;
    end
  end

  assign busy_o = (state == S_WAIT);
  assign err_o  = |err_flags_o;

endmodule
